// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared SHA-256 datapath types: shift/rotate op encoding.
// Used by the pipelined barrel shifter and its stages.
package sha_datapath_pkg;

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        SHL  = OP_SHL,
        SHR  = OP_SHR,
        SRA  = OP_SRA,
        ROTR = OP_ROTR
    } shift_op_e;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready bundle for the barrel shifter: request side
// (in_*) and result side (out_*); slave is the shifter.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag,
        output out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag,
        input  out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One registered shift stage of distance 2**STAGE.
// PIPELINED_BARREL_SHIFTER_ROTATE_EN enables ROTR wrap.
module barrel_shift_stage
    import sha_datapath_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 8,
    parameter int SHAMT_W = 5,
    parameter int STAGE   = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               upValid,
    output logic               upReady,
    input  logic [WIDTH-1:0]   upData,
    input  logic [SHAMT_W-1:0] upShamt,
    input  shift_op_e          upOp,
    input  logic [TAG_W-1:0]   upTag,
    input  logic               dnReady,
    output logic               dnValid,
    output logic [WIDTH-1:0]   dnData,
    output logic [SHAMT_W-1:0] dnShamt,
    output shift_op_e          dnOp,
    output logic [TAG_W-1:0]   dnTag
);

    localparam int DIST = 1 << STAGE;

    logic             load;
    logic [WIDTH-1:0] shifted;

    // Empty slots accept even while downstream stalls.
    assign load    = !dnValid || dnReady;
    assign upReady = load;

    // SRA keeps the operand MSB in place, so the sign rides along.
    always_comb begin
        shifted = upData;
        if (upShamt[STAGE]) begin
            unique case (1'b1)
                upOp == SHL:  shifted = upData << DIST;
                upOp == SRA:  shifted = $signed(upData) >>> DIST;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                upOp == ROTR: shifted = {upData[DIST-1:0],
                                         upData[WIDTH-1:DIST]};
`endif
                default:      shifted = upData >> DIST;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dnValid <= 1'b0;
            dnData  <= '0;
            dnShamt <= '0;
            dnOp    <= SHL;
            dnTag   <= '0;
        end else if (load) begin
            dnValid <= upValid;
            if (upValid) begin
                dnData  <= shifted;
                dnShamt <= upShamt;
                dnOp    <= upOp;
                dnTag   <= upTag;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// log2(WIDTH)-stage shift/rotate pipeline, LSB distance first.
// ROTR wrap controlled by PIPELINED_BARREL_SHIFTER_ROTATE_EN.
module pipelined_barrel_shifter
    import sha_datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
) (
    input logic                        clock,
    input logic                        reset_n,
    pipelined_barrel_shifter_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W:0]              valid;
    logic [SHAMT_W:0]              ready;
    logic [SHAMT_W:0][WIDTH-1:0]   data;
    logic [SHAMT_W:0][SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0][TAG_W-1:0]   tag;
    shift_op_e                     op [SHAMT_W+1];
    logic                          unusedCtl;

    assign valid[0] = bus.in_valid;
    assign data[0]  = bus.in_data;
    assign shamt[0] = bus.in_shamt;
    assign op[0]    = shift_op_e'(bus.in_op);
    assign tag[0]   = bus.in_tag;
    assign bus.in_ready = ready[0];

    assign ready[SHAMT_W] = bus.out_ready;
    assign bus.out_valid  = valid[SHAMT_W];
    assign bus.out_data   = data[SHAMT_W];
    assign bus.out_tag    = tag[SHAMT_W];

    // Final stage control is consumed and has no reader.
    assign unusedCtl = ^{shamt[SHAMT_W], op[SHAMT_W]};

    for (genvar k = 0; k < SHAMT_W; k++) begin : gStage
        barrel_shift_stage #(
            .WIDTH   (WIDTH),
            .TAG_W   (TAG_W),
            .SHAMT_W (SHAMT_W),
            .STAGE   (k)
        ) uStage (
            .clock   (clock),
            .reset_n (reset_n),
            .upValid (valid[k]),
            .upReady (ready[k]),
            .upData  (data[k]),
            .upShamt (shamt[k]),
            .upOp    (op[k]),
            .upTag   (tag[k]),
            .dnReady (ready[k+1]),
            .dnValid (valid[k+1]),
            .dnData  (data[k+1]),
            .dnShamt (shamt[k+1]),
            .dnOp    (op[k+1]),
            .dnTag   (tag[k+1])
        );
    end

endmodule
